// File: rtl/sram_wait_ctrl.sv
// Async-SRAM controller for the native mem bus: 32-bit window over LANES x16 chips.
// Read/write timing comes from wait-state parameters; all SRAM pins are registered.
module sram_wait_ctrl #(
  parameter int unsigned ADDR_W    = 18,
  parameter int unsigned LANES     = 2,
  parameter logic [31:0] BASE      = 32'h2000_0000,
  parameter logic [31:0] BASE_MASK = 32'hf000_0000,
  parameter int unsigned RD_WAIT   = 1,
  parameter int unsigned WR_SETUP  = 0,
  parameter int unsigned WR_PULSE  = 1,
  parameter int unsigned WR_HOLD   = 0
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  mem_valid,
  input  logic [31:0]           mem_addr,
  input  logic [31:0]           mem_wdata,
  input  logic [3:0]            mem_wstrb,
  output logic                  mem_ready,
  output logic [31:0]           mem_rdata,
  output logic [ADDR_W-1:0]     sram_addr,
  output logic [16*LANES-1:0]   sram_dq_out,
  output logic                  sram_dq_oe,
  input  logic [16*LANES-1:0]   sram_dq_in,
  output logic                  sram_ce_n,
  output logic                  sram_oe_n,
  output logic [LANES-1:0]      sram_we_n,
  output logic [LANES-1:0]      sram_lb_n,
  output logic [LANES-1:0]      sram_ub_n
);

  typedef enum logic [2:0] {StIdle, StRd, StWsu, StWpl, StWhd, StDone} state_e;

  // Counters hold (cycles - 1); a state is left when its count reaches zero.
  localparam logic [3:0] RdCnt = 4'(RD_WAIT - 1);
  localparam logic [3:0] SuCnt = 4'(WR_SETUP - 1);
  localparam logic [3:0] PlCnt = 4'(WR_PULSE - 1);
  localparam logic [3:0] HdCnt = 4'(WR_HOLD - 1);

  state_e           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [3:0]       wstrb_q, wstrb_d;
  logic             hit, accept;
  logic             ce_n_d, oe_n_d, dq_oe_d, ready_d;
  logic [LANES-1:0] we_n_d, lb_n_d, ub_n_d;

  assign hit    = (mem_addr & BASE_MASK) == BASE;
  assign accept = (state_q == StIdle) && mem_valid && hit && !mem_ready;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          if (mem_wstrb == 4'b0000) begin
            state_d = StRd;
            cnt_d   = RdCnt;
          end else if (WR_SETUP != 0) begin
            state_d = StWsu;
            cnt_d   = SuCnt;
          end else begin
            state_d = StWpl;
            cnt_d   = PlCnt;
          end
        end
      end
      StRd: begin
        if (cnt_q == 4'd0) state_d = StDone;
        else               cnt_d   = cnt_q - 4'd1;
      end
      StWsu: begin
        if (cnt_q == 4'd0) begin
          state_d = StWpl;
          cnt_d   = PlCnt;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StWpl: begin
        if (cnt_q == 4'd0) begin
          if (WR_HOLD != 0) begin
            state_d = StWhd;
            cnt_d   = HdCnt;
          end else begin
            state_d = StDone;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StWhd: begin
        if (cnt_q == 4'd0) state_d = StDone;
        else               cnt_d   = cnt_q - 4'd1;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Pin values are decoded from the next state so the pins themselves can be flops.
  always_comb begin
    wstrb_d = accept ? mem_wstrb : wstrb_q;
    ce_n_d  = 1'b1;
    oe_n_d  = 1'b0;
    dq_oe_d = 1'b0;
    we_n_d  = '1;
    lb_n_d  = '1;
    ub_n_d  = '1;
    ready_d = (state_d == StDone);
    unique case (state_d)
      StRd: begin
        ce_n_d = 1'b0;
        lb_n_d = '0;
        ub_n_d = '0;
      end
      StWsu, StWpl, StWhd: begin
        ce_n_d  = 1'b0;
        oe_n_d  = 1'b1;
        dq_oe_d = 1'b1;
        for (int k = 0; k < LANES; k++) begin
          lb_n_d[k] = ~wstrb_d[2*k];
          ub_n_d[k] = ~wstrb_d[2*k+1];
          if (state_d == StWpl) we_n_d[k] = ~(wstrb_d[2*k] | wstrb_d[2*k+1]);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q     <= StIdle;
      cnt_q       <= 4'd0;
      wstrb_q     <= 4'd0;
      mem_ready   <= 1'b0;
      mem_rdata   <= '0;
      sram_addr   <= '0;
      sram_dq_out <= '0;
      sram_dq_oe  <= 1'b0;
      sram_ce_n   <= 1'b1;
      sram_oe_n   <= 1'b0;
      sram_we_n   <= '1;
      sram_lb_n   <= '1;
      sram_ub_n   <= '1;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      wstrb_q    <= wstrb_d;
      mem_ready  <= ready_d;
      sram_dq_oe <= dq_oe_d;
      sram_ce_n  <= ce_n_d;
      sram_oe_n  <= oe_n_d;
      sram_we_n  <= we_n_d;
      sram_lb_n  <= lb_n_d;
      sram_ub_n  <= ub_n_d;
      if (accept) begin
        sram_addr   <= mem_addr[ADDR_W+1:2];
        sram_dq_out <= mem_wdata;
      end
      if (state_q == StRd && cnt_q == 4'd0) mem_rdata <= sram_dq_in;
    end
  end

endmodule

// File: tb/tb_sram_wait_ctrl.sv
// Bench for sram_wait_ctrl: default-timing instance (A, with a small SRAM model) and a
// slow-timing instance (B); table-driven accesses checked through a scoreboard queue.
module tb_sram_wait_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        resetn, sel, valid_a, valid_b;
  logic [31:0] addr, wdata;
  logic [3:0]  wstrb;

  logic        rdy_a, dqoe_a, ce_a, oe_a, rdy_b, dqoe_b, ce_b, oe_b;
  logic [31:0] rdata_a, dqo_a, dqi_a, rdata_b, dqo_b, dq_b;
  logic [17:0] sa_a, sa_b;
  logic [1:0]  we_a, lb_a, ub_a, we_b, lb_b, ub_b;
  logic        force_a;
  logic [31:0] force_val;
  logic [31:0] mem [16];

  int total = 0;
  int bad   = 0;

  sram_wait_ctrl u_dut_a (
    .clk(clk), .resetn(resetn), .mem_valid(valid_a), .mem_addr(addr), .mem_wdata(wdata),
    .mem_wstrb(wstrb), .mem_ready(rdy_a), .mem_rdata(rdata_a), .sram_addr(sa_a),
    .sram_dq_out(dqo_a), .sram_dq_oe(dqoe_a), .sram_dq_in(dqi_a), .sram_ce_n(ce_a),
    .sram_oe_n(oe_a), .sram_we_n(we_a), .sram_lb_n(lb_a), .sram_ub_n(ub_a)
  );

  sram_wait_ctrl #(.RD_WAIT(3), .WR_SETUP(1), .WR_PULSE(2), .WR_HOLD(1)) u_dut_b (
    .clk(clk), .resetn(resetn), .mem_valid(valid_b), .mem_addr(addr), .mem_wdata(wdata),
    .mem_wstrb(wstrb), .mem_ready(rdy_b), .mem_rdata(rdata_b), .sram_addr(sa_b),
    .sram_dq_out(dqo_b), .sram_dq_oe(dqoe_b), .sram_dq_in(dq_b), .sram_ce_n(ce_b),
    .sram_oe_n(oe_b), .sram_we_n(we_b), .sram_lb_n(lb_b), .sram_ub_n(ub_b)
  );

  // Behavioural byte-laned SRAM behind instance A (16 words, low address bits only).
  always @(posedge clk) begin
    if (!ce_a) begin
      for (int k = 0; k < 2; k++) begin
        if (!we_a[k]) begin
          if (!lb_a[k]) mem[sa_a[3:0]][16*k +: 8]   <= dqo_a[16*k +: 8];
          if (!ub_a[k]) mem[sa_a[3:0]][16*k+8 +: 8] <= dqo_a[16*k+8 +: 8];
        end
      end
    end
  end
  assign dqi_a = force_a ? force_val : ((!ce_a && !oe_a) ? mem[sa_a[3:0]] : 32'h0);

  logic        s_rdy, s_ce, s_dqoe;
  logic [1:0]  s_we, s_lb, s_ub;
  logic [31:0] s_rdata, s_dqo;
  logic [17:0] s_sa;
  assign s_rdy   = sel ? rdy_b   : rdy_a;
  assign s_ce    = sel ? ce_b    : ce_a;
  assign s_dqoe  = sel ? dqoe_b  : dqoe_a;
  assign s_we    = sel ? we_b    : we_a;
  assign s_lb    = sel ? lb_b    : lb_a;
  assign s_ub    = sel ? ub_b    : ub_a;
  assign s_rdata = sel ? rdata_b : rdata_a;
  assign s_dqo   = sel ? dqo_b   : dqo_a;
  assign s_sa    = sel ? sa_b    : sa_a;

  typedef struct {
    logic        sel;
    logic [31:0] addr, wdata;
    logic [3:0]  wstrb;
    logic        frc;
    logic [31:0] dq;
    logic        ramp, hit, keep;
    int          lat;
    logic [31:0] rdata;
    logic [17:0] saddr;
  } vec_t;

  typedef struct {
    int          lat;
    logic        rd;
    logic [31:0] rdata;
    logic [17:0] saddr;
  } exp_t;

  exp_t sb[$];

  logic [1:0]  we_tr [64];
  logic [1:0]  lb_tr [64];
  logic [1:0]  ub_tr [64];
  logic        oe_tr [64];
  logic        ce_tr [64];
  logic [31:0] dqo_tr[64];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic s, input logic [31:0] a, input logic [31:0] wd,
                              input logic [3:0] st, input logic frc, input logic [31:0] dq,
                              input logic ramp, input logic hit, input logic keep, input int lat,
                              input logic [31:0] rd, input logic [17:0] sa);
    vec_t v;
    v.sel = s; v.addr = a; v.wdata = wd; v.wstrb = st; v.frc = frc; v.dq = dq;
    v.ramp = ramp; v.hit = hit; v.keep = keep; v.lat = lat; v.rdata = rd; v.saddr = sa;
    return v;
  endfunction

  // Cycle 0 is the request cycle T; ready is expected at cycle v.lat.
  task automatic run_vec(input vec_t v);
    exp_t e;
    int   cyc, lim;
    bit   seen, ce_low, we_low;
    @(posedge clk); #1;
    sel = v.sel; addr = v.addr; wdata = v.wdata; wstrb = v.wstrb;
    force_a = v.frc; force_val = v.dq; dq_b = v.dq;
    if (v.sel) valid_b = 1'b1;
    else       valid_a = 1'b1;
    if (v.hit) begin
      e.lat = v.lat; e.rd = (v.wstrb == 4'b0000); e.rdata = v.rdata; e.saddr = v.saddr;
      sb.push_back(e);
    end
    lim = v.hit ? 40 : 20;
    seen = 0; cyc = 0; ce_low = 0; we_low = 0;
    while (!seen && cyc <= lim) begin
      @(negedge clk);
      if (v.ramp) dq_b = v.dq + 32'(cyc);
      we_tr[cyc] = s_we; lb_tr[cyc] = s_lb; ub_tr[cyc] = s_ub;
      oe_tr[cyc] = s_dqoe; ce_tr[cyc] = s_ce; dqo_tr[cyc] = s_dqo;
      if (!s_ce) ce_low = 1;
      if (s_we != 2'b11) we_low = 1;
      if (s_rdy) seen = 1;
      else       cyc++;
    end
    if (v.hit) begin
      check("ready_seen", 64'(seen), 64'd1);
      e = sb.pop_front();
      check("latency", 64'(cyc), 64'(e.lat));
      if (e.rd) check("rdata", 64'(s_rdata), 64'(e.rdata));
      check("sram_addr", 64'(s_sa), 64'(e.saddr));
    end else begin
      check("nohit_ready", 64'(seen), 64'd0);
      check("nohit_ce_n", 64'(ce_low), 64'd0);
      check("nohit_we_n", 64'(we_low), 64'd0);
    end
    if (!v.keep) begin
      @(posedge clk); #1;
      valid_a = 1'b0;
      valid_b = 1'b0;
    end
  endtask

  // Slow write (setup 1, pulse 2, hold 1) with wstrb 0110: both lanes pulse.
  task automatic check_wr_trace();
    for (int c = 1; c <= 5; c++) begin
      check($sformatf("wr_we_n[%0d]", c), 64'(we_tr[c]),
            64'((c == 2 || c == 3) ? 2'b00 : 2'b11));
      check($sformatf("wr_dq_oe[%0d]", c), 64'(oe_tr[c]), 64'(c <= 4));
      check($sformatf("wr_ce_n[%0d]", c), 64'(ce_tr[c]), 64'(c == 5));
      if (c <= 4) begin
        check($sformatf("wr_lb_n[%0d]", c), 64'(lb_tr[c]), 64'(2'b01));
        check($sformatf("wr_ub_n[%0d]", c), 64'(ub_tr[c]), 64'(2'b10));
      end
    end
    check("wr_dq_out", 64'(dqo_tr[2]), 64'h1122_3344);
  endtask

  vec_t vecs[11];
  vec_t v;
  int   rdy_cnt;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 32'h0;
    resetn = 1'b0; sel = 1'b0; valid_a = 1'b0; valid_b = 1'b0;
    addr = '0; wdata = '0; wstrb = '0; force_a = 1'b1; force_val = '0; dq_b = '0;

    //                s  addr          wdata         strb  frc dq            rmp hit keep lat rdata         saddr
    vecs[0]  = mk(0, 32'h2000_0008, 32'h0,        4'h0, 1, 32'hDEAD_BEEF, 0, 1, 0, 2, 32'hDEAD_BEEF, 18'h2);
    vecs[1]  = mk(0, 32'h2000_0004, 32'hCAFE_F00D, 4'hF, 0, 32'h0,        0, 1, 1, 2, 32'h0,        18'h1);
    vecs[2]  = mk(0, 32'h2000_0004, 32'h0,        4'h0, 0, 32'h0,        0, 1, 1, 2, 32'hCAFE_F00D, 18'h1);
    vecs[3]  = mk(0, 32'h2000_0004, 32'h00AA_0000, 4'h4, 0, 32'h0,        0, 1, 1, 2, 32'h0,        18'h1);
    vecs[4]  = mk(0, 32'h2010_0004, 32'h0,        4'h0, 0, 32'h0,        0, 1, 0, 2, 32'hCAAA_F00D, 18'h1);
    vecs[5]  = mk(1, 32'h2000_0020, 32'h0,        4'h0, 1, 32'h1000_0000, 1, 1, 0, 4, 32'h1000_0003, 18'h8);
    vecs[6]  = mk(1, 32'h2000_0010, 32'h1122_3344, 4'h6, 1, 32'h0,        0, 1, 0, 5, 32'h0,        18'h4);
    vecs[7]  = mk(0, 32'h3000_0000, 32'hFFFF_FFFF, 4'hF, 1, 32'h0,        0, 0, 0, 0, 32'h0,        18'h0);
    vecs[8]  = mk(0, 32'h2FFF_FFFC, 32'h0,        4'h0, 1, 32'h0123_4567, 0, 1, 0, 2, 32'h0123_4567, 18'h3FFFF);
    vecs[9]  = mk(0, 32'h1FFF_FFFC, 32'h0,        4'h0, 1, 32'h0,        0, 0, 0, 0, 32'h0,        18'h0);
    vecs[10] = mk(1, 32'h2000_0014, 32'h0,        4'h0, 1, 32'h0A0B_0C00, 0, 1, 0, 4, 32'h0A0B_0C00, 18'h5);

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ready", 64'(rdy_a), 64'd0);
    check("rst_rdata", 64'(rdata_a), 64'd0);
    check("rst_addr", 64'(sa_a), 64'd0);
    check("rst_dq_out", 64'(dqo_a), 64'd0);
    check("rst_pins", 64'({dqoe_a, ce_a, oe_a, we_a, lb_a, ub_a}), 64'(9'b0_1_0_11_11_11));
    check("rst_ce_n_b", 64'(ce_b), 64'd1);
    @(posedge clk); #1;
    resetn = 1'b1;

    for (int i = 0; i < 11; i++) begin
      run_vec(vecs[i]);
      if (i == 6) check_wr_trace();
    end

    // Reset asserted during the write pulse abandons the access.
    @(posedge clk); #1;
    sel = 1'b1; addr = 32'h2000_0030; wdata = 32'h5A5A_A5A5; wstrb = 4'hF; valid_b = 1'b1;
    @(negedge clk);
    @(negedge clk);
    @(posedge clk); #1;
    resetn = 1'b0; valid_b = 1'b0;
    @(negedge clk);
    check("rst5_in_wpl", 64'(we_b), 64'(2'b00));
    @(posedge clk); #1;
    resetn = 1'b1;
    @(negedge clk);
    check("rst5_we_n", 64'(we_b), 64'(2'b11));
    check("rst5_dq_oe", 64'(dqoe_b), 64'd0);
    check("rst5_ce_n", 64'(ce_b), 64'd1);
    rdy_cnt = 0;
    for (int c = 0; c < 8; c++) begin
      if (rdy_b || rdy_a) rdy_cnt++;
      @(negedge clk);
    end
    check("rst5_no_ready", 64'(rdy_cnt), 64'd0);
    v = mk(1, 32'h2000_0030, 32'h0, 4'h0, 1, 32'h5555_0000, 1, 1, 0, 4, 32'h5555_0003, 18'hC);
    run_vec(v);

    check("sb_empty", 64'(sb.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
